// File: rtl/cordic_result_buffer.sv
// cordic_result_buffer
// Small FIFO between the descale stage and the result consumer. The descale
// stage cannot be stalled, so results arriving while the buffer is full (and
// no pop happens in that cycle) are dropped and recorded in a sticky overflow.
// The head entry is held in output registers so that x/y/z/tag_out come
// straight from flops and stay stable while the consumer stalls.
module cordic_result_buffer #(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_MARGIN = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        x_in,
  input  logic [DATA_W-1:0]        y_in,
  input  logic [DATA_W-1:0]        z_in,
  input  logic [TAG_W-1:0]         tag_in,
  input  logic                     done_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        x_out,
  output logic [DATA_W-1:0]        y_out,
  output logic [DATA_W-1:0]        z_out,
  output logic [TAG_W-1:0]         tag_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 3 * DATA_W + TAG_W;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef logic [ENT_W-1:0] entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  entry_t             head_q, head_d;
  entry_t             in_entry;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   rd_next;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic               overflow_q, overflow_d;
  logic               push, pop, drop;

  assign in_entry = {x_in, y_in, z_in, tag_in};
  assign rd_next  = rd_ptr_q + PTR_W'(1);

  // Handshake decode: a full buffer still accepts a result if the head leaves this cycle.
  always_comb begin
    pop  = out_valid_q & out_ready;
    push = done_in & ((count_q != DEPTH_C) | pop);
    drop = done_in & ~push;
  end

  // Next-state for pointers, occupancy, head registers and storage.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_next              : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // The head copy only changes when the head leaves or an empty buffer fills;
    // with a single entry popped alongside a push, the pushed result is next.
    head_d = head_q;
    if (pop) begin
      if (count_q > ONE_C) begin
        head_d = mem_q[rd_next];
      end else if (push) begin
        head_d = in_entry;
      end
    end else if (push && (count_q == '0)) begin
      head_d = in_entry;
    end

    out_valid_d = (count_d != '0);
    overflow_d  = overflow_q | drop;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
    end
  end

  // Control and head registers, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      head_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      head_q      <= head_d;
    end
  end

  // Storage array carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign out_valid   = out_valid_q;
  assign overflow    = overflow_q;
  assign count       = count_q;
  assign almost_full = (count_q >= AF_LEVEL);
  assign {x_out, y_out, z_out, tag_out} = head_q;

endmodule

// File: tb/tb_cordic_result_buffer.sv
// Bench for cordic_result_buffer: a table of per-cycle vectors for the single
// and burst cases, then hand sequences for overflow, full push+pop, random
// backpressure against a queue model, and asynchronous reset mid-burst.
module tb_cordic_result_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] x_in = '0, y_in = '0, z_in = '0;
  logic [7:0]  tag_in = '0;
  logic        done_in = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] x_out, y_out, z_out;
  logic [7:0]  tag_out;
  logic [2:0]  count;
  logic        almost_full;
  logic        overflow;

  int n_checks = 0;
  int n_err    = 0;

  cordic_result_buffer dut (
    .clock(clock), .reset(reset),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .tag_in(tag_in), .done_in(done_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .tag_out(tag_out),
    .count(count), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        done;
    logic        ready;
    logic [31:0] xi, yi, zi;
    logic [7:0]  ti;
    logic        ev;
    logic [31:0] ex, ey, ez;
    logic [7:0]  et;
    logic [2:0]  ecnt;
    logic        eaf;
    logic        eov;
    logic        chk_data;
  } vec_t;

  typedef struct {
    logic [31:0] x, y, z;
    logic [7:0]  t;
  } ent_t;

  vec_t vecs[$];
  ent_t model[$];

  function automatic logic [31:0] fx(input logic [7:0] t); return 32'hA5A5_0000 | {24'h0, t}; endfunction
  function automatic logic [31:0] fy(input logic [7:0] t); return 32'h8000_0000 | {16'h0, t, 8'h3C}; endfunction
  function automatic logic [31:0] fz(input logic [7:0] t); return {t, 24'h00_0F0F}; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Adds a vector using tag-derived data for both input and expected head.
  task automatic addv(input logic done, input logic ready, input logic [7:0] ti,
                      input logic ev, input logic [7:0] et, input logic [2:0] ecnt,
                      input logic eaf, input logic eov);
    vec_t v;
    v.done = done; v.ready = ready;
    v.xi = fx(ti); v.yi = fy(ti); v.zi = fz(ti); v.ti = ti;
    v.ev = ev; v.ex = fx(et); v.ey = fy(et); v.ez = fz(et); v.et = et;
    v.ecnt = ecnt; v.eaf = eaf; v.eov = eov; v.chk_data = ev;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic done, input logic ready, input logic [7:0] t);
    done_in = done; out_ready = ready; tag_in = t;
    x_in = fx(t); y_in = fy(t); z_in = fz(t);
  endtask

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic chk_head(input string name, input logic [7:0] t);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_tag"}, 32'(tag_out), 32'(t));
    chk({name, "_x"}, x_out, fx(t));
    chk({name, "_z"}, z_out, fz(t));
  endtask

  task automatic do_reset;
    reset = 1'b0; drive(1'b0, 1'b0, 8'h00);
    #12; reset = 1'b1;
    tick;
  endtask

  task automatic fill4;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      tick;
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  // Checks head before each pop, so each expected tag is the one being accepted.
  task automatic drain(input string name, input logic [7:0] t0, input logic [7:0] t1,
                       input logic [7:0] t2, input logic [7:0] t3);
    logic [7:0] exp_t [4];
    exp_t[0] = t0; exp_t[1] = t1; exp_t[2] = t2; exp_t[3] = t3;
    for (int i = 0; i < 4; i++) begin
      chk_head(name, exp_t[i]);
      drive(1'b0, 1'b1, 8'h00);
      tick;
    end
    chk({name, "_empty"}, 32'(out_valid), 32'd0);
    chk({name, "_cnt0"}, 32'(count), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [31:0] sx, sy, sz;
    logic [7:0]  st;
    logic        stalled;
    logic        m_ov;
    logic        m_pop, m_push;
    ent_t        e;

    // Test 1: single result with explicit data values.
    v = '{done:1'b1, ready:1'b1, xi:32'h0000_1000, yi:32'hFFFF_F000, zi:32'h1234_5678, ti:8'h05,
          ev:1'b1, ex:32'h0000_1000, ey:32'hFFFF_F000, ez:32'h1234_5678, et:8'h05,
          ecnt:3'd1, eaf:1'b0, eov:1'b0, chk_data:1'b1};
    vecs.push_back(v);
    addv(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    // Test 2: burst fill with consumer stalled, then drain.
    addv(1'b1, 1'b0, 8'd1, 1'b1, 8'd1, 3'd1, 1'b0, 1'b0);
    addv(1'b1, 1'b0, 8'd2, 1'b1, 8'd1, 3'd2, 1'b0, 1'b0);
    addv(1'b1, 1'b0, 8'd3, 1'b1, 8'd1, 3'd3, 1'b1, 1'b0);
    addv(1'b1, 1'b0, 8'd4, 1'b1, 8'd1, 3'd4, 1'b1, 1'b0);
    addv(1'b0, 1'b1, 8'd0, 1'b1, 8'd2, 3'd3, 1'b1, 1'b0);
    addv(1'b0, 1'b1, 8'd0, 1'b1, 8'd3, 3'd2, 1'b0, 1'b0);
    addv(1'b0, 1'b1, 8'd0, 1'b1, 8'd4, 3'd1, 1'b0, 1'b0);
    addv(1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0);

    reset = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    chk("rst_x", x_out, 32'd0);
    reset = 1'b1;
    tick;

    foreach (vecs[i]) begin
      done_in = vecs[i].done; out_ready = vecs[i].ready;
      x_in = vecs[i].xi; y_in = vecs[i].yi; z_in = vecs[i].zi; tag_in = vecs[i].ti;
      tick;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d_af", i), 32'(almost_full), 32'(vecs[i].eaf));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].eov));
      if (vecs[i].chk_data) begin
        chk($sformatf("vec%0d_x", i), x_out, vecs[i].ex);
        chk($sformatf("vec%0d_y", i), y_out, vecs[i].ey);
        chk($sformatf("vec%0d_z", i), z_out, vecs[i].ez);
        chk($sformatf("vec%0d_tag", i), 32'(tag_out), 32'(vecs[i].et));
      end
    end
    drive(1'b0, 1'b0, 8'h00);

    // Test 3: result arriving while full and stalled is dropped.
    fill4;
    drive(1'b1, 1'b0, 8'd9);
    tick;
    drive(1'b0, 1'b0, 8'h00);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    drain("ovf_drain", 8'd1, 8'd2, 8'd3, 8'd4);
    tick;
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Test 4: push and pop together while full.
    do_reset;
    chk("rst2_ovf", 32'(overflow), 32'd0);
    fill4;
    drive(1'b1, 1'b1, 8'd7);
    tick;
    drive(1'b0, 1'b0, 8'h00);
    chk("fpp_ovf", 32'(overflow), 32'd0);
    chk("fpp_count", 32'(count), 32'd4);
    drain("fpp_drain", 8'd2, 8'd3, 8'd4, 8'd7);

    // Test 4b: single entry popped while a new one is pushed.
    drive(1'b1, 1'b0, 8'h21);
    tick;
    drive(1'b1, 1'b1, 8'h22);
    tick;
    drive(1'b0, 1'b0, 8'h00);
    chk("c1pp_count", 32'(count), 32'd1);
    chk_head("c1pp_head", 8'h22);
    drive(1'b0, 1'b1, 8'h00);
    tick;
    drive(1'b0, 1'b0, 8'h00);

    // Test 5: random backpressure with random arrivals against a queue model.
    do_reset;
    model.delete();
    m_ov = 1'b0;
    stalled = 1'b0;
    sx = '0; sy = '0; sz = '0; st = '0;
    for (int c = 0; c < 200; c++) begin
      done_in   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      x_in = $urandom; y_in = $urandom; z_in = $urandom; tag_in = 8'($urandom);
      m_pop  = (model.size() != 0) && out_ready;
      m_push = done_in && ((model.size() < 4) || m_pop);
      e.x = x_in; e.y = y_in; e.z = z_in; e.t = tag_in;
      stalled = (model.size() != 0) && !out_ready;
      sx = x_out; sy = y_out; sz = z_out; st = tag_out;
      if (m_pop) void'(model.pop_front());
      if (m_push) model.push_back(e);
      if (done_in && !m_push) m_ov = 1'b1;
      tick;
      chk("bp_valid", 32'(out_valid), 32'(model.size() != 0));
      chk("bp_count", 32'(count), 32'(model.size()));
      chk("bp_ovf", 32'(overflow), 32'(m_ov));
      if (model.size() != 0) begin
        chk("bp_tag", 32'(tag_out), 32'(model[0].t));
        chk("bp_x", x_out, model[0].x);
        chk("bp_y", y_out, model[0].y);
        chk("bp_z", z_out, model[0].z);
      end
      if (stalled) begin
        chk("bp_stable", {x_out ^ sx} | {y_out ^ sy} | {z_out ^ sz} | 32'(tag_out ^ st), 32'd0);
      end
    end
    drive(1'b0, 1'b0, 8'h00);

    // Test 6: asynchronous reset between edges with three entries and overflow set.
    do_reset;
    fill4;
    drive(1'b1, 1'b0, 8'd9);
    tick;
    drive(1'b0, 1'b1, 8'h00);
    tick;
    drive(1'b0, 1'b0, 8'h00);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    #3;
    reset = 1'b1;
    tick;
    drive(1'b1, 1'b0, 8'h3C);
    tick;
    drive(1'b0, 1'b0, 8'h00);
    chk("post_rst_count", 32'(count), 32'd1);
    chk_head("post_rst", 8'h3C);
    tick;
    chk("post_rst_hold", 32'(tag_out), 32'h3C);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
